// File: rtl/mul_pkg.sv
// Shared definitions for the sequential RV32M multiplier: data width,
// mul_op encodings and the controller state type.
package mul_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes one multiplier bit per cycle, then applies
// the sign fix-up and picks the low or high word of the 2*length product.
// Optional build macro MUL_EARLY_TERM_EN: leave CALC as soon as the
// remaining multiplier bits are all zero.
module mul_seq
    import mul_pkg::*;
#(
    parameter int length = XLEN,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [length-1:0] oper_a,
    input  logic [length-1:0] oper_b,
    input  logic [1:0]        mul_op,
    input  logic              enable_mul,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [length-1:0] mul_o
);

    localparam int PW = 2 * length;

    mul_state_t        state;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [length-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic              neg;
    logic [1:0]        op_q;

    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [length-1:0] a_mag;
    logic [length-1:0] b_mag;
    logic [PW-1:0]     acc_add;
    logic [length-1:0] mplier_shr;
    logic [PW-1:0]     product;
    logic              last_iter;

    // Operand signedness by opcode and two's-complement magnitudes; the most
    // negative value maps to 2^(length-1) when read unsigned.
    always_comb begin
        a_signed = (mul_op != MUL_OP_MULHU);
        b_signed = (mul_op == MUL_OP_MUL) || (mul_op == MUL_OP_MULH);
        a_neg    = a_signed & oper_a[length-1];
        b_neg    = b_signed & oper_b[length-1];
        a_mag    = a_neg ? (~oper_a + length'(1)) : oper_a;
        b_mag    = b_neg ? (~oper_b + length'(1)) : oper_b;
    end

    // One shift-add step, the signed product and the CALC exit condition.
    always_comb begin
        acc_add    = mplier[0] ? (acc + mcand) : acc;
        mplier_shr = mplier >> 1;
        product    = neg ? (~acc + PW'(1)) : acc;
`ifdef MUL_EARLY_TERM_EN
        last_iter  = (cnt == CNT_W'(length - 1)) || (mplier_shr == '0);
`else
        last_iter  = (cnt == CNT_W'(length - 1));
`endif
    end

    // Controller and datapath registers; outputs are registered here too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            op_q     <= MUL_OP_MUL;
            mul_busy <= 1'b0;
            mul_done <= 1'b0;
            mul_o    <= '0;
        end else begin
            mul_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_mul) begin
                        mcand    <= {{length{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        neg      <= a_neg ^ b_neg;
                        op_q     <= mul_op;
                        acc      <= '0;
                        cnt      <= '0;
                        mul_busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shr;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    mul_o    <= (op_q == MUL_OP_MUL) ? product[length-1:0]
                                                     : product[PW-1:length];
                    mul_done <= 1'b1;
                    mul_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
